// File: rtl/fpu_issue_queue.sv
// FP issue queue: decodes OP-FP instructions into a FIFO and issues them one at a time to
// the FPU or the matmul unit. Optional watchdog enabled by defining FPU_TIMEOUT_EN.
module fpu_issue_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic [4:0] rd,
  output logic       in_ready,
  output logic       illegal_op,
  output logic [2:0] FPUControl,
  output logic       FPUStart,
  output logic       MatmulStart,
  output logic [4:0] issue_rd,
  input  logic       FPUDone,
  input  logic       MatmulDone,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [6:0] OpFp = 7'b1010011;

  typedef struct packed {
    logic       mm;
    logic [2:0] ctrl;
    logic [4:0] rd;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StWaitFpu, StWaitMm} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic            illegal_q, illegal_d;
  logic            fpu_start_q, fpu_start_d;
  logic            mm_start_q, mm_start_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [4:0]      issue_rd_q, issue_rd_d;
  logic            timeout_q, timeout_d;

  entry_t dec;
  entry_t head;
  logic   dec_legal, is_opfp, push, pop;

  always_comb begin
    dec_legal = 1'b1;
    dec.mm    = 1'b0;
    dec.ctrl  = 3'b000;
    dec.rd    = rd;
    case (funct7)
      7'b0000000: dec.ctrl = 3'b000;
      7'b0000100: dec.ctrl = 3'b001;
      7'b0001000: dec.ctrl = 3'b010;
      7'b0001100: dec.ctrl = 3'b011;
      7'b0101100: begin
        if (funct3 == 3'b000) dec.ctrl = 3'b100;
        else                  dec_legal = 1'b0;
      end
      7'b0010100: begin
        if (funct3 == 3'b000)      dec.ctrl = 3'b101;
        else if (funct3 == 3'b001) dec.ctrl = 3'b110;
        else                       dec_legal = 1'b0;
      end
      7'b0010000: dec.mm = 1'b1;
      default:    dec_legal = 1'b0;
    endcase
  end

  assign is_opfp   = (op == OpFp);
  assign in_ready  = (count_q < DepthC);
  assign push      = in_valid && in_ready && is_opfp && dec_legal;
  assign illegal_d = in_valid && is_opfp && !dec_legal;
  assign head      = mem_q[rd_ptr_q];

`ifdef FPU_TIMEOUT_EN
  localparam int unsigned WdRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WdW   = (WdRaw < 8) ? 8 : ((WdRaw > 16) ? 16 : WdRaw);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
  logic [WdW-1:0] wd_q, wd_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    fpu_start_d = 1'b0;
    mm_start_d  = 1'b0;
    ctrl_d      = 3'b000;
    issue_rd_d  = issue_rd_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          issue_rd_d = head.rd;
          if (head.mm) begin
            state_d    = StWaitMm;
            mm_start_d = 1'b1;
          end else begin
            state_d     = StWaitFpu;
            fpu_start_d = 1'b1;
            ctrl_d      = head.ctrl;
          end
        end
      end
      StWaitFpu: if (FPUDone) state_d = StIdle;
      StWaitMm:  if (MatmulDone) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
`ifdef FPU_TIMEOUT_EN
    // A done on the same edge as expiry wins; no timeout is reported then.
    if (state_q != StIdle && state_d == state_q && wd_q == WdLast) begin
      state_d   = StIdle;
      timeout_d = 1'b1;
    end
    wd_d = (state_d != StIdle && state_d == state_q) ? wd_q + WdW'(1) : '0;
`endif
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = dec;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      illegal_q   <= 1'b0;
      fpu_start_q <= 1'b0;
      mm_start_q  <= 1'b0;
      ctrl_q      <= 3'b000;
      issue_rd_q  <= 5'd0;
      timeout_q   <= 1'b0;
`ifdef FPU_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      illegal_q   <= illegal_d;
      fpu_start_q <= fpu_start_d;
      mm_start_q  <= mm_start_d;
      ctrl_q      <= ctrl_d;
      issue_rd_q  <= issue_rd_d;
      timeout_q   <= timeout_d;
`ifdef FPU_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  // Storage holds no state that matters while count is zero, so it is not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign illegal_op  = illegal_q;
  assign FPUStart    = fpu_start_q;
  assign MatmulStart = mm_start_q;
  assign FPUControl  = ctrl_q;
  assign issue_rd    = issue_rd_q;
  assign busy        = (state_q != StIdle) || (count_q != '0);
`ifdef FPU_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
  logic unused_timeout_q;
  assign unused_timeout_q = timeout_q;
`endif

endmodule
